// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: a main register drives out_data and a skid
// register absorbs one beat, so in_ready can come from registered state only.
module pipe_stage_skid #(
  parameter int DATA_W      = 120,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // state | meaning
  // EMPTY | no beat held; main may hold a stale or zero payload
  // ONE   | main holds the head beat, skid free
  // TWO   | main holds the head beat, skid holds the next one; upstream stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  generate
    if (DATA_W < 1 || DATA_W > 1024) begin : g_bad_width
      $error("pipe_stage_skid: DATA_W out of range 1..1024");
    end
  endgenerate

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              emit;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (ZERO_BUBBLE != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (emit && !accept) begin
            state_d = EMPTY;
          end else if (accept && emit) begin
            main_d = in_data;
          end
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      if (ZERO_BUBBLE != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  // With ZERO_BUBBLE the idle bus reads zero even though main keeps the last beat.
  assign out_data  = (ZERO_BUBBLE != 0 && !out_valid_q) ? '0 : main_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid against hand values and a reference queue.
module tb_pipe_stage_skid;

  localparam int DATA_W = 120;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int tests_run;
  int tests_failed;

  pipe_stage_skid #(.DATA_W(DATA_W), .ZERO_BUBBLE(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic ov,
                           input logic ir, input logic [DATA_W-1:0] dat);
    chk({tag, ".occ"}, 128'(occupancy), 128'(occ));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(ir));
    chk({tag, ".out_data"}, 128'(out_data), 128'(dat));
  endtask

  logic [DATA_W-1:0] ref_q[$];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_state("reset", 2'd0, 1'b0, 1'b1, '0);

    // single beat, out_ready held high
    in_valid = 1'b1; in_data = 'hA5; out_ready = 1'b1;
    tick();
    chk_state("single", 2'd1, 1'b1, 1'b1, 'hA5);
    in_valid = 1'b0;
    tick();
    chk_state("single_drain", 2'd0, 1'b0, 1'b1, '0);

    // back-pressure: beats 1,2 held, beat 3 refused
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'd1;
    tick();
    chk_state("bp_b1", 2'd1, 1'b1, 1'b1, 'd1);
    in_data = 'd2;
    tick();
    chk_state("bp_b2", 2'd2, 1'b1, 1'b0, 'd1);
    in_data = 'd3;
    tick();
    chk_state("bp_b3_refused", 2'd2, 1'b1, 1'b0, 'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_state("bp_emit1", 2'd1, 1'b1, 1'b1, 'd2);
    tick();
    chk_state("bp_emit2", 2'd0, 1'b0, 1'b1, '0);
    tick();
    chk_state("bp_no_b3", 2'd0, 1'b0, 1'b1, '0);

    // full-throughput stream
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = DATA_W'(i + 1);
      tick();
      chk_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1, DATA_W'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream_drain", 2'd0, 1'b0, 1'b1, '0);

    // flush from TWO with a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'd7;
    tick();
    in_data = 'd8;
    tick();
    chk_state("fl_two", 2'd2, 1'b1, 1'b0, 'd7);
    flush = 1'b1; in_data = 'd9;
    tick();
    chk_state("fl_two_cleared", 2'd0, 1'b0, 1'b1, '0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_state("fl_no_b9", 2'd0, 1'b0, 1'b1, '0);

    // flush from ONE with in_ready=1 and emit in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'd5;
    tick();
    flush = 1'b1; in_data = 'd6; out_ready = 1'b1;
    tick();
    chk_state("fl_one_cleared", 2'd0, 1'b0, 1'b1, '0);
    flush = 1'b0; in_valid = 1'b0;

    // in_data toggling with in_valid low under back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk_state($sformatf("idle_toggle%0d", i), 2'd1, 1'b1, 1'b1, 'h3C);
    end
    out_ready = 1'b1;
    tick();
    chk_state("idle_drain", 2'd0, 1'b0, 1'b1, '0);

    // reset while full, with a beat offered during reset
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'h11;
    tick();
    in_data = 'h22;
    tick();
    chk_state("rst_full", 2'd2, 1'b1, 1'b0, 'h11);
    rst = 1'b1; in_data = 'h55; out_ready = 1'b1;
    tick();
    chk_state("rst_cleared", 2'd0, 1'b0, 1'b1, '0);
    rst = 1'b0; in_data = 'h66; out_ready = 1'b0;
    tick();
    chk_state("rst_first_beat", 2'd1, 1'b1, 1'b1, 'h66);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_state("rst_drain", 2'd0, 1'b0, 1'b1, '0);

    // randomized traffic against a reference queue
    ref_q.delete();
    for (int c = 0; c < 10000; c++) begin
      int sz;
      logic iv, ordy, fl;
      logic [DATA_W-1:0] d;
      sz = ref_q.size();
      if (occupancy !== 2'(sz)) chk($sformatf("rnd%0d.occ", c), 128'(occupancy), 128'(sz));
      if (out_valid !== (sz > 0)) chk($sformatf("rnd%0d.out_valid", c), 128'(out_valid), 128'(sz > 0));
      if (in_ready !== (sz < 2)) chk($sformatf("rnd%0d.in_ready", c), 128'(in_ready), 128'(sz < 2));
      chk("rnd.out_data", 128'(out_data), (sz > 0) ? 128'(ref_q[0]) : 128'(0));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      d    = {DATA_W'($urandom) << 64, 32'($urandom), 32'(c)};
      in_valid = iv; out_ready = ordy; flush = fl; in_data = d;
      if (fl) begin
        ref_q.delete();
      end else begin
        if (sz > 0 && ordy) void'(ref_q.pop_front());
        if (iv && sz < 2) ref_q.push_back(d);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
